// File: rtl/dpe_pkg.sv
// rtl/dpe_pkg.sv - shared types, sizes and lane helper for the dot-product engine
package dpe_pkg;

    localparam int LANES    = 4;
    localparam int LANE_W   = 8;
    localparam int PROD_W   = 16;
    localparam int WORD_W   = LANES * LANE_W;
    localparam int ACC_W    = 32;
    localparam int WT_DEPTH = 256;
    localparam int ADDR_W   = 8;
    localparam int LEN_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed int8 held in lane i of a packed word
    function automatic logic signed [LANE_W-1:0] lane(input logic [WORD_W-1:0] word, input int i);
        return word[i*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/dpe_mul4.sv
// rtl/dpe_mul4.sv - 4-lane signed 8x8 multiplier with registered S1 products
module dpe_mul4 import dpe_pkg::*; (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic [WORD_W-1:0]         i_act,
    input  logic [WORD_W-1:0]         i_wt,
    output logic                      o_valid,
    output logic [LANES*PROD_W-1:0]   o_prod
);

    logic [LANES*PROD_W-1:0] w_prod;
    logic                    r_valid;
    logic [LANES*PROD_W-1:0] r_prod;

    // Lane-wise products; sign-extend both operands so the 16-bit product is exact
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod[i*PROD_W +: PROD_W] = PROD_W'(PROD_W'(lane(i_act, i)) * PROD_W'(lane(i_wt, i)));
        end
    end

    // S1 register: products only update on a valid pop, valid bit follows every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - FIFO-fed int8 dot-product engine; DPE_RELU_EN clamps negative results to 0
module dot_product_engine import dpe_pkg::*; (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_len,
    output logic                o_busy,
    output logic                o_fifo_read_enable,
    input  logic [WORD_W-1:0]   i_fifo_read_data,
    input  logic                i_fifo_empty,
    input  logic                i_wt_we,
    input  logic [ADDR_W-1:0]   i_wt_addr,
    input  logic [WORD_W-1:0]   i_wt_data,
    output logic                o_result_valid,
    input  logic                i_result_ready,
    output logic [ACC_W-1:0]    o_result_data
);

    state_t                   r_state;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_count;
    logic                     r_drain_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_result_valid;
    logic [ACC_W-1:0]         r_result_data;
    logic [WORD_W-1:0]        r_wt_mem [WT_DEPTH];

    logic                     w_pop;
    logic [WORD_W-1:0]        w_wt_word;
    logic                     w_s1_valid;
    logic [LANES*PROD_W-1:0]  w_s1_prod;
    logic signed [ACC_W-1:0]  w_s1_sum;
    logic [LEN_W-1:0]         w_len_clamped;
    logic [ACC_W-1:0]         w_result_next;

    // A pop is a cycle in RUN with a word at the FIFO head; each one consumes a word
    assign w_pop              = (r_state == RUN) && !i_fifo_empty;
    assign o_fifo_read_enable = w_pop;
    assign o_busy             = (r_state != IDLE);
    assign o_result_valid     = r_result_valid;
    assign o_result_data      = r_result_data;

    // Word k of the job pairs with weight k, so the pop counter is the weight index
    assign w_wt_word     = r_wt_mem[r_count[ADDR_W-1:0]];
    assign w_len_clamped = (i_len > LEN_W'(WT_DEPTH)) ? LEN_W'(WT_DEPTH) : i_len;

`ifdef DPE_RELU_EN
    assign w_result_next = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign w_result_next = r_acc;
`endif

    dpe_mul4 u_mul4 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_pop),
        .i_act   (i_fifo_read_data),
        .i_wt    (w_wt_word),
        .o_valid (w_s1_valid),
        .o_prod  (w_s1_prod)
    );

    // S2 adder input: sign-extended sum of the four registered products
    always_comb begin
        w_s1_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_s1_sum = w_s1_sum + ACC_W'($signed(w_s1_prod[i*PROD_W +: PROD_W]));
        end
    end

    // Weight RAM is not reset; writes land only while the engine is idle
    always_ff @(posedge i_clk) begin
        if (i_wt_we && (r_state == IDLE)) begin
            r_wt_mem[i_wt_addr] <= i_wt_data;
        end
    end

    // Job FSM with accumulator; DRAIN waits two cycles so the last product reaches acc
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_count        <= '0;
            r_drain_cnt    <= 1'b0;
            r_acc          <= '0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
        end else begin
            if (w_s1_valid) begin
                r_acc <= r_acc + w_s1_sum;
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_len       <= w_len_clamped;
                        r_count     <= '0;
                        r_acc       <= '0;
                        r_drain_cnt <= 1'b0;
                        if (w_len_clamped == '0) begin
                            r_state        <= DONE;
                            r_result_valid <= 1'b1;
                            r_result_data  <= '0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_count <= r_count + LEN_W'(1);
                        if ((r_count + LEN_W'(1)) == r_len) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state        <= DONE;
                        r_result_valid <= 1'b1;
                        r_result_data  <= w_result_next;
                    end
                end
                DONE: begin
                    if (i_result_ready) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b0;
                        r_result_data  <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - self-checking bench for dot_product_engine against an arithmetic model
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic        busy;
    logic        fre;
    logic [31:0] fdata = 32'hDEADBEEF;
    logic        fifo_empty = 1'b1;
    logic        wt_we = 1'b0;
    logic [7:0]  wt_addr = '0;
    logic [31:0] wt_data = '0;
    logic        rv;
    logic        rready = 1'b0;
    logic [31:0] rd;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pop_count = 0;
    int bad_pops = 0;
    int last_pop = -1;
    int seen_pops = 0;
    int stall_cnt = 0;
    int gap = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] wt_model[256];

    always #5 clk = ~clk;

    dot_product_engine dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_len              (len),
        .o_busy             (busy),
        .o_fifo_read_enable (fre),
        .i_fifo_read_data   (fdata),
        .i_fifo_empty       (fifo_empty),
        .i_wt_we            (wt_we),
        .i_wt_addr          (wt_addr),
        .i_wt_data          (wt_data),
        .o_result_valid     (rv),
        .i_result_ready     (rready),
        .o_result_data      (rd)
    );

    // Pop monitor: cycle T is the cycle ending at this edge
    always @(posedge clk) begin
        if (fre) begin
            if (fifo_empty) bad_pops++;
            pop_count++;
            last_pop = cyc;
        end
        cyc++;
    end

    // FIFO model: retire popped words, insert stall gaps, present head word
    always @(negedge clk) begin
        while (seen_pops < pop_count) begin
            if (fifo_q.size() > 0) fifo_q.delete(0);
            seen_pops++;
            stall_cnt = gap;
        end
        if (stall_cnt > 0) begin
            fifo_empty = 1'b1;
            stall_cnt--;
        end else begin
            fifo_empty = (fifo_q.size() == 0);
        end
        fdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEADBEEF;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    function automatic int lane_s(input logic [31:0] w, input int i);
        logic signed [7:0] b;
        b = w[8*i +: 8];
        return int'(b);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] words[$], input int n);
        int s;
        int m;
        s = 0;
        m = (n > 256) ? 256 : n;
        for (int k = 0; k < m; k++)
            for (int i = 0; i < 4; i++)
                s += lane_s(words[k], i) * lane_s(wt_model[k], i);
`ifdef DPE_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic write_wt(input int addr, input logic [31:0] data, input bit accepted);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 8'(addr); wt_data = data;
        @(negedge clk);
        wt_we = 1'b0;
        if (accepted) wt_model[addr] = data;
    endtask

    task automatic push_words(input logic [31:0] w[$]);
        foreach (w[k]) fifo_q.push_back(w[k]);
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1; len = 9'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit seen, output int vcyc);
        seen = 0; vcyc = -1;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (rv) begin seen = 1; vcyc = cyc; end
        end
    endtask

    task automatic run_job(input int n, output logic [31:0] res, output bit seen, output int vcyc, output int npops);
        int p0;
        p0 = pop_count;
        pulse_start(n);
        wait_valid(seen, vcyc);
        res = rd;
        npops = pop_count - p0;
    endtask

    task automatic accept();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (fre !== 1'b0) begin n_fail++; $display("FAIL reset_fre: got %b expected 0", fre); end
        n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rv); end
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", rd); end
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np;
        w = '{32'h04030201};
        write_wt(0, 32'h01010101, 1);
        push_words(w);
        run_job(1, res, seen, vcyc, np);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_valid: got none expected result_valid"); end
        n_checks++; if (np !== 1) begin n_fail++; $display("FAIL basic_pops: got %0d expected 1", np); end
        n_checks++; if (vcyc !== last_pop + 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", vcyc - last_pop, 3); end
        n_checks++; if (res !== 32'd10) begin n_fail++; $display("FAIL basic_result: got %0h expected %0h", res, 32'd10); end
        accept();
        n_checks++; if (rv !== 1'b0 || rd !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_release: got valid=%b data=%0h busy=%b expected 0 0 0", rv, rd, busy); end
    endtask

    task automatic test_extremes();
        logic [31:0] tw[2];
        logic [31:0] tx[2];
        logic [31:0] te[2];
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np;
        tw[0] = 32'h80808080; tx[0] = 32'h80808080; te[0] = 32'd65536;
        tw[1] = 32'h01010101; tx[1] = 32'hFFFFFFFF;
`ifdef DPE_RELU_EN
        te[1] = 32'd0;
`else
        te[1] = 32'hFFFFFFFC;
`endif
        for (int t = 0; t < 2; t++) begin
            write_wt(0, tw[t], 1);
            w = '{tx[t]};
            push_words(w);
            run_job(1, res, seen, vcyc, np);
            n_checks++; if (res !== te[t]) begin n_fail++; $display("FAIL extreme_%0d: got %0h expected %0h", t, res, te[t]); end
            accept();
        end
    endtask

    task automatic test_stall();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np, b0;
        for (int k = 0; k < 3; k++) write_wt(k, $urandom, 1);
        w = '{};
        for (int k = 0; k < 3; k++) w.push_back($urandom);
        gap = 4;
        b0 = bad_pops;
        push_words(w);
        run_job(3, res, seen, vcyc, np);
        gap = 0;
        n_checks++; if (np !== 3) begin n_fail++; $display("FAIL stall_pops: got %0d expected 3", np); end
        n_checks++; if (bad_pops !== b0) begin n_fail++; $display("FAIL stall_read_while_empty: got %0d expected %0d", bad_pops, b0); end
        n_checks++; if (res !== model(w, 3)) begin n_fail++; $display("FAIL stall_result: got %0h expected %0h", res, model(w, 3)); end
        accept();
    endtask

    task automatic test_hold();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np, p0, bad;
        for (int k = 0; k < 2; k++) write_wt(k, $urandom, 1);
        w = '{$urandom, $urandom};
        push_words(w);
        run_job(2, res, seen, vcyc, np);
        n_checks++; if (res !== model(w, 2)) begin n_fail++; $display("FAIL hold_result: got %0h expected %0h", res, model(w, 2)); end
        fifo_q.push_back($urandom);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2); len = 9'd1;
            @(negedge clk);
            if (rv !== 1'b1 || rd !== res) bad++;
        end
        start = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        p0 = pop_count;
        start = 1'b1; len = 9'd1;
        accept();
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || pop_count !== p0) begin n_fail++; $display("FAIL hold_start_ignored: got busy=%b pops=%0d expected busy=0 pops=0", busy, pop_count - p0); end
        fifo_q.delete();
        @(negedge clk);
        w = '{};
        run_job(0, res, seen, vcyc, np);
        n_checks++; if (!seen || res !== 32'd0 || np !== 0) begin n_fail++; $display("FAIL zero_len: got seen=%b data=%0h pops=%0d expected 1 0 0", seen, res, np); end
        accept();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np, p0;
        for (int k = 0; k < 4; k++) write_wt(k, $urandom, 1);
        w = '{$urandom, $urandom, $urandom, $urandom};
        push_words(w);
        p0 = pop_count;
        pulse_start(4);
        for (int k = 0; k < 200 && (pop_count - p0) < 2; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || fre !== 1'b0 || rv !== 1'b0) begin n_fail++; $display("FAIL midreset_drop: got busy=%b fre=%b valid=%b expected 0 0 0", busy, fre, rv); end
        @(negedge clk);
        n_checks++; if (pop_count - p0 !== 2) begin n_fail++; $display("FAIL midreset_pops: got %0d expected 2", pop_count - p0); end
        rst_n = 1'b1;
        @(negedge clk);
        fifo_q.delete();
        @(negedge clk);
        write_wt(0, $urandom, 1);
        w = '{$urandom};
        push_words(w);
        run_job(1, res, seen, vcyc, np);
        n_checks++; if (res !== model(w, 1) || np !== 1) begin n_fail++; $display("FAIL midreset_recover: got %0h pops=%0d expected %0h pops=1", res, np, model(w, 1)); end
        accept();
    endtask

    task automatic test_relu_and_wt_lock();
        logic [31:0] w[$];
        logic [31:0] res;
        logic [31:0] exp_c;
        bit seen;
        int vcyc;
        write_wt(0, 32'h01010101, 1);
        write_wt(1, 32'h01010101, 1);
        pulse_start(2);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL relu_busy: got %b expected 1", busy); end
        write_wt(1, 32'h7F7F7F7F, 0);
        w = '{32'h000000F5, 32'h00000001};
        push_words(w);
        wait_valid(seen, vcyc);
        res = rd;
`ifdef DPE_RELU_EN
        exp_c = 32'd0;
`else
        exp_c = 32'hFFFFFFF6;
`endif
        n_checks++; if (res !== exp_c || res !== model(w, 2)) begin n_fail++; $display("FAIL relu_result: got %0h expected %0h", res, exp_c); end
        accept();
    endtask

    task automatic test_clamp();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np;
        for (int k = 0; k < 256; k++) write_wt(k, $urandom, 1);
        w = '{};
        for (int k = 0; k < 260; k++) w.push_back($urandom);
        push_words(w);
        run_job(300, res, seen, vcyc, np);
        n_checks++; if (np !== 256) begin n_fail++; $display("FAIL clamp_pops: got %0d expected 256", np); end
        n_checks++; if (res !== model(w, 300)) begin n_fail++; $display("FAIL clamp_result: got %0h expected %0h", res, model(w, 300)); end
        accept();
        fifo_q.delete();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        logic [31:0] res;
        bit seen;
        int vcyc, np, n;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) write_wt(k, $urandom, 1);
            w = '{};
            for (int k = 0; k < n; k++) w.push_back($urandom);
            gap = $urandom_range(0, 2);
            push_words(w);
            run_job(n, res, seen, vcyc, np);
            n_checks++; if (res !== model(w, n) || np !== n) begin n_fail++; $display("FAIL b2b_job%0d: got %0h pops=%0d expected %0h pops=%0d", j, res, np, model(w, n), n); end
            accept();
        end
        gap = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_hold();
        test_reset_mid();
        test_relu_and_wt_lock();
        test_clamp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
